lfsr_checker_fibonacci: RTL



---
 rtl/lfsr_checker_fibonacci.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lfsr_checker_fibonacci.sv
// Serial PRBS checker for the Fibonacci LFSR generator: self-seeds from the received
// stream, verifies predictions before declaring lock, then counts bit errors.
module lfsr_checker_fibonacci #(
    parameter int unsigned LOCK_GOOD     = 8,
    parameter int unsigned UNLOCK_THRESH = 4,
    parameter int unsigned ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       lfsr_length,
    input  logic             lfsr_n_taps,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             cfg_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_INVALID = 2'd0;
    localparam logic [1:0] ST_SEED    = 2'd1;
    localparam logic [1:0] ST_VERIFY  = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam logic [7:0]       LOCK_GOOD_C = 8'(LOCK_GOOD);
    localparam logic [3:0]       UNLOCK_C    = 4'(UNLOCK_THRESH);
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    logic [15:0] mask;
    logic        mask_valid;
    logic [15:0] len_mask;
    logic        cfg_change;
    logic        predicted;
    logic [15:0] sr_shift;
    logic [3:0]  seed_inc;
    logic [7:0]  good_inc;
    logic [3:0]  miss_inc;

    logic [3:0]       cfg_len_q,   cfg_len_d;
    logic             cfg_taps_q,  cfg_taps_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic [1:0]       state_q,     state_d;
    logic [15:0]      sr_q,        sr_d;
    logic [3:0]       seed_cnt_q,  seed_cnt_d;
    logic [7:0]       good_cnt_q,  good_cnt_d;
    logic [3:0]       miss_cnt_q,  miss_cnt_d;
    logic             locked_q,    locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    // Tap tables shared bit-for-bit with the generator; tap k maps to mask bit k-1.
    always_comb begin
        mask = 16'h0000;
        case ({lfsr_n_taps, lfsr_length})
            5'b0_0010: mask = 16'h0003;
            5'b0_0011: mask = 16'h0006;
            5'b0_0100: mask = 16'h000C;
            5'b0_0101: mask = 16'h0014;
            5'b0_0110: mask = 16'h0030;
            5'b0_0111: mask = 16'h0060;
            5'b0_1001: mask = 16'h0110;
            5'b0_1010: mask = 16'h0240;
            5'b0_1011: mask = 16'h0500;
            5'b0_1111: mask = 16'h6000;
            5'b1_0101: mask = 16'h001E;
            5'b1_0110: mask = 16'h0036;
            5'b1_0111: mask = 16'h0078;
            5'b1_1000: mask = 16'h00B8;
            5'b1_1001: mask = 16'h01B0;
            5'b1_1010: mask = 16'h0360;
            5'b1_1011: mask = 16'h0740;
            5'b1_1100: mask = 16'h0CA0;
            5'b1_1101: mask = 16'h1B00;
            5'b1_1110: mask = 16'h3500;
            5'b1_1111: mask = 16'h7400;
            default:   mask = 16'h0000;
        endcase
    end

    assign mask_valid = |mask;
    assign len_mask   = ~(16'hFFFF << lfsr_length);
    assign cfg_change = (lfsr_length != cfg_len_q) || (lfsr_n_taps != cfg_taps_q);
    assign predicted  = ^(sr_q & mask);
    assign sr_shift   = {sr_q[14:0], bit_in};
    assign seed_inc   = seed_cnt_q + 4'd1;
    assign good_inc   = good_cnt_q + 8'd1;
    assign miss_inc   = miss_cnt_q + 4'd1;

    always_comb begin
        cfg_len_d   = lfsr_length;
        cfg_taps_d  = lfsr_n_taps;
        cfg_valid_d = mask_valid;
        state_d     = state_q;
        sr_d        = sr_q;
        seed_cnt_d  = seed_cnt_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = (state_q == ST_LOCKED);
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        // A config change discards the bit in flight; the error count survives it.
        if (cfg_change || !mask_valid) begin
            state_d    = mask_valid ? ST_SEED : ST_INVALID;
            sr_d       = 16'h0000;
            seed_cnt_d = 4'd0;
            good_cnt_d = 8'd0;
            miss_cnt_d = 4'd0;
        end else if (state_q == ST_INVALID) begin
            state_d = ST_SEED;
        end else if (bit_valid) begin
            sr_d = sr_shift;
            case (state_q)
                ST_SEED: begin
                    seed_cnt_d = seed_inc;
                    if (seed_inc == lfsr_length) begin
                        seed_cnt_d = 4'd0;
                        // An all-zero seed is the LFSR lockup state: keep seeding.
                        if ((sr_shift & len_mask) != 16'h0000) begin
                            state_d    = ST_VERIFY;
                            good_cnt_d = 8'd0;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (bit_in == predicted) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_GOOD_C) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = 8'd0;
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d    = ST_SEED;
                        seed_cnt_d = 4'd0;
                        good_cnt_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (bit_in != predicted) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == UNLOCK_C) begin
                            state_d    = ST_SEED;
                            seed_cnt_d = 4'd0;
                            good_cnt_d = 8'd0;
                            miss_cnt_d = 4'd0;
                        end
                    end else if (miss_cnt_q != 4'd0) begin
                        miss_cnt_d = miss_cnt_q - 4'd1;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end

        if (clear) err_count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_len_q   <= 4'd0;
            cfg_taps_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            state_q     <= ST_SEED;
            sr_q        <= 16'h0000;
            seed_cnt_q  <= 4'd0;
            good_cnt_q  <= 8'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            cfg_len_q   <= cfg_len_d;
            cfg_taps_q  <= cfg_taps_d;
            cfg_valid_q <= cfg_valid_d;
            state_q     <= state_d;
            sr_q        <= sr_d;
            seed_cnt_q  <= seed_cnt_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign cfg_valid = cfg_valid_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule
